cv32e40x_mpu_gate: RTL and testbench

Transaction gate between a core requester (instruction fetch or LSU) and its OBI-facing bus interface. It presents the request address to the PMA, consumes the PMA verdict, and decides per transaction:
- If the PMA allows it, the transaction is forwarded to the bus with the bufferable/cacheable attributes.
- If the PMA rejects it, the transaction is absorbed and answered with a locally generated fault response, in order with all earlier bus responses.

It also tracks outstanding bus transactions, so that ordering is preserved and the outstanding limit is enforced.

---
 rtl/cv32e40x_mpu_gate_if.sv | 23 ++
 rtl/cv32e40x_mpu_gate.sv | 109 ++++++++++
 tb/tb_cv32e40x_mpu_gate.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_mpu_gate_if.sv
// Bus-side request/response channel between the MPU gate (master) and the OBI interface (slave).
interface cv32e40x_mpu_gate_if;
   logic        trans_valid;
   logic        trans_ready;
   logic [31:0] trans_addr;
   logic [31:0] trans_wdata;
   logic        trans_we;
   logic        trans_bufferable;
   logic        trans_cacheable;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output trans_valid, trans_addr, trans_wdata, trans_we, trans_bufferable, trans_cacheable,
      input  trans_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  trans_valid, trans_addr, trans_wdata, trans_we, trans_bufferable, trans_cacheable,
      output trans_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/cv32e40x_mpu_gate.sv
// Gates core transactions on the PMA verdict: legal ones go to the bus, rejected ones get a
// local fault response ordered behind all outstanding bus responses.
module cv32e40x_mpu_gate #(
   parameter bit          IF_STAGE        = 1'b0,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_trans_valid_i,
   output logic        core_trans_ready_o,
   input  logic [31:0] core_trans_addr_i,
   input  logic        core_trans_we_i,
   input  logic [31:0] core_trans_wdata_i,
   output logic [31:0] pma_addr_o,
   input  logic        pma_err_i,
   input  logic        pma_bufferable_i,
   input  logic        pma_cacheable_i,
   cv32e40x_mpu_gate_if.master bus,
   output logic        core_resp_valid_o,
   output logic [31:0] core_resp_rdata_o,
   output logic        core_resp_err_o,
   output logic [1:0]  core_mpu_status_o,
   output logic        busy_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, RD_ERR, WR_ERR} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          we_eff;
   logic          room;
   logic          bus_valid;
   logic          fault_accept;
   logic          inc, dec;

   assign we_eff = IF_STAGE ? 1'b0 : core_trans_we_i;
   assign room   = cnt < MAX_CNT;

   // Fault is only taken with nothing outstanding, so it cannot overtake a bus response.
   assign fault_accept = (state == IDLE) && core_trans_valid_i && pma_err_i && (cnt == '0);

   assign pma_addr_o            = core_trans_addr_i;
   assign bus.trans_addr        = core_trans_addr_i;
   assign bus.trans_wdata       = core_trans_wdata_i;
   assign bus.trans_we          = we_eff;
   assign bus.trans_bufferable  = pma_bufferable_i;
   assign bus.trans_cacheable   = pma_cacheable_i;
   assign bus.trans_valid       = bus_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      if (fault_accept) state_nxt = we_eff ? WR_ERR : RD_ERR;
   end

   always_comb begin
      bus_valid          = 1'b0;
      core_trans_ready_o = 1'b0;
      core_resp_valid_o  = bus.resp_valid;
      core_resp_rdata_o  = bus.resp_rdata;
      core_resp_err_o    = bus.resp_err;
      core_mpu_status_o  = 2'b00;
      case (state)
         IDLE: begin
            if (!pma_err_i) begin
               bus_valid          = core_trans_valid_i && room;
               core_trans_ready_o = bus.trans_ready && room;
            end else if (core_trans_valid_i) begin
               core_trans_ready_o = (cnt == '0);
            end
         end
         RD_ERR, WR_ERR: begin
            core_resp_valid_o = 1'b1;
            core_resp_rdata_o = '0;
            core_resp_err_o   = 1'b0;
            core_mpu_status_o = (state == WR_ERR) ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   assign inc = bus_valid && bus.trans_ready;
   assign dec = bus.resp_valid && (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case ({inc, dec})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign busy_o = (cnt != '0) || (state != IDLE);

   resp_without_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      bus.resp_valid |-> (cnt != '0));

endmodule

// File: tb/tb_cv32e40x_mpu_gate.sv
// Directed bench for cv32e40x_mpu_gate: an LSU instance and a fetch instance share stimulus.
module tb_cv32e40x_mpu_gate;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, we = 1'b0, perr = 1'b0, pbuf = 1'b0, pcach = 1'b0;
   logic [31:0] addr = 32'h0000_1234, wdata = '0;
   logic        bready = 1'b0, rvalid = 1'b0, rerr = 1'b0;
   logic [31:0] rdata = '0;

   logic        l_ready, l_rvalid, l_rerr, l_busy;
   logic [31:0] l_pma_addr, l_rdata;
   logic [1:0]  l_status;
   logic        f_ready, f_rvalid, f_rerr, f_busy;
   logic [31:0] f_pma_addr, f_rdata;
   logic [1:0]  f_status;

   int unsigned checks = 0;
   int unsigned errors = 0;

   cv32e40x_mpu_gate_if bus_l ();
   cv32e40x_mpu_gate_if bus_f ();

   assign bus_l.trans_ready = bready;
   assign bus_l.resp_valid  = rvalid;
   assign bus_l.resp_rdata  = rdata;
   assign bus_l.resp_err    = rerr;
   assign bus_f.trans_ready = bready;
   assign bus_f.resp_valid  = rvalid;
   assign bus_f.resp_rdata  = rdata;
   assign bus_f.resp_err    = rerr;

   cv32e40x_mpu_gate #(.IF_STAGE(1'b0), .MAX_OUTSTANDING(2)) u_lsu (
      .clk(clk), .rst_n(rst_n),
      .core_trans_valid_i(valid), .core_trans_ready_o(l_ready),
      .core_trans_addr_i(addr), .core_trans_we_i(we), .core_trans_wdata_i(wdata),
      .pma_addr_o(l_pma_addr), .pma_err_i(perr),
      .pma_bufferable_i(pbuf), .pma_cacheable_i(pcach),
      .bus(bus_l.master),
      .core_resp_valid_o(l_rvalid), .core_resp_rdata_o(l_rdata), .core_resp_err_o(l_rerr),
      .core_mpu_status_o(l_status), .busy_o(l_busy)
   );

   cv32e40x_mpu_gate #(.IF_STAGE(1'b1), .MAX_OUTSTANDING(2)) u_fetch (
      .clk(clk), .rst_n(rst_n),
      .core_trans_valid_i(valid), .core_trans_ready_o(f_ready),
      .core_trans_addr_i(addr), .core_trans_we_i(we), .core_trans_wdata_i(wdata),
      .pma_addr_o(f_pma_addr), .pma_err_i(perr),
      .pma_bufferable_i(pbuf), .pma_cacheable_i(pcach),
      .bus(bus_f.master),
      .core_resp_valid_o(f_rvalid), .core_resp_rdata_o(f_rdata), .core_resp_err_o(f_rerr),
      .core_mpu_status_o(f_status), .busy_o(f_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_ready",    32'(l_ready), 32'h0);
      chk("rst_bus_valid",32'(bus_l.trans_valid), 32'h0);
      chk("rst_resp",     32'(l_rvalid), 32'h0);
      chk("rst_status",   32'(l_status), 32'h0);
      chk("rst_busy",     32'(l_busy), 32'h0);
      chk("rst_pma_addr", l_pma_addr, 32'h0000_1234);
      tick(); tick();
      rst_n = 1'b1;

      // Legal load, same-cycle forward, response one cycle later
      tick();
      valid = 1'b1; addr = 32'h0000_1000; bready = 1'b1; pbuf = 1'b1; pcach = 1'b0;
      #1;
      chk("ld_bus_valid", 32'(bus_l.trans_valid), 32'h1);
      chk("ld_ready",     32'(l_ready), 32'h1);
      chk("ld_bus_addr",  bus_l.trans_addr, 32'h0000_1000);
      chk("ld_buf",       32'(bus_l.trans_bufferable), 32'h1);
      chk("ld_cach",      32'(bus_l.trans_cacheable), 32'h0);
      tick();
      valid = 1'b0; pbuf = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      chk("ld_busy",      32'(l_busy), 32'h1);
      chk("ld_rvalid",    32'(l_rvalid), 32'h1);
      chk("ld_rdata",     l_rdata, 32'hDEAD_BEEF);
      chk("ld_status",    32'(l_status), 32'h0);
      tick();
      rvalid = 1'b0;
      #1;
      chk("ld_cnt_zero",  32'(u_lsu.cnt), 32'h0);

      // Faulting store, no bus request, fault response next cycle
      tick();
      valid = 1'b1; we = 1'b1; perr = 1'b1; addr = 32'h1A11_0000; wdata = 32'h5555_AAAA;
      #1;
      chk("st_ready",     32'(l_ready), 32'h1);
      chk("st_bus_valid", 32'(bus_l.trans_valid), 32'h0);
      tick();
      valid = 1'b0; we = 1'b0; perr = 1'b0;
      #1;
      chk("st_rvalid",    32'(l_rvalid), 32'h1);
      chk("st_status",    32'(l_status), 32'h2);
      chk("st_rdata",     l_rdata, 32'h0);
      chk("st_ready_err", 32'(l_ready), 32'h0);
      chk("if_st_status", 32'(f_status), 32'h1);
      tick();
      chk("st_rvalid_end",32'(l_rvalid), 32'h0);
      chk("st_busy_end",  32'(l_busy), 32'h0);

      // Two legal loads outstanding, then a faulting load must wait for both responses
      valid = 1'b1; addr = 32'h0000_2000; pcach = 1'b1;
      #1;
      chk("f_buf_fetch",  32'(bus_f.trans_cacheable), 32'h1);
      tick();
      addr = 32'h0000_2004;
      tick();
      addr = 32'h0000_2008; perr = 1'b1;
      #1;
      chk("ord_stall0",   32'(l_ready), 32'h0);
      tick();
      rvalid = 1'b1; rdata = 32'h0000_000A;
      #1;
      chk("ord_stall1",   32'(l_ready), 32'h0);
      chk("ord_resp1",    l_rdata, 32'h0000_000A);
      tick();
      rdata = 32'h0000_000B;
      #1;
      chk("ord_stall_last", 32'(l_ready), 32'h0);
      chk("ord_resp2_st", 32'(l_status), 32'h0);
      tick();
      rvalid = 1'b0;
      #1;
      chk("ord_accept",   32'(l_ready), 32'h1);
      chk("ord_no_resp",  32'(l_rvalid), 32'h0);
      tick();
      valid = 1'b0; perr = 1'b0;
      #1;
      chk("ord_fault_rv", 32'(l_rvalid), 32'h1);
      chk("ord_fault_st", 32'(l_status), 32'h1);
      tick();

      // Outstanding limit with responses withheld
      valid = 1'b1; pcach = 1'b0; addr = 32'h0000_3000;
      tick();
      tick();
      #1;
      chk("lim_cnt2",     32'(u_lsu.cnt), 32'h2);
      chk("lim_valid0",   32'(bus_l.trans_valid), 32'h0);
      chk("lim_ready0",   32'(l_ready), 32'h0);
      rvalid = 1'b1; rdata = 32'h0000_0C0C;
      #1;
      chk("lim_resp_cyc", 32'(bus_l.trans_valid), 32'h0);
      tick();
      #1;
      chk("lim_issue",    32'(bus_l.trans_valid), 32'h1);
      chk("lim_issue_rdy",32'(l_ready), 32'h1);
      tick();
      valid = 1'b0;
      #1;
      chk("lim_same_cyc", 32'(u_lsu.cnt), 32'h1);
      tick();
      rvalid = 1'b0;
      #1;
      chk("lim_drained",  32'(l_busy), 32'h0);

      // Reset during RD_ERR drops the fault response
      valid = 1'b1; perr = 1'b1; we = 1'b0;
      tick();
      valid = 1'b0; perr = 1'b0;
      #1;
      chk("rst_rd_err",   32'(l_rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_drop",     32'(l_rvalid), 32'h0);
      chk("rst_mid_busy", 32'(l_busy), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_cnt", 32'(u_lsu.cnt), 32'h0);
      chk("post_rst_busy",32'(l_busy), 32'h0);
      chk("post_rst_rv",  32'(l_rvalid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
